// File: rtl/rd_ptr_empty_tx.sv
// Read-domain control for the tx asynchronous FIFO.
// Owns the binary/Gray read pointer, synchronises the Gray write pointer into
// the read clock, and produces registered empty, almost-empty and fill count.
// Optional build macro: SYNC_3FF_EN selects a 3-flop write-pointer
// synchroniser (4-edge flag latency) instead of the default 2 flops (3 edges).
//
// Handshake: a read is accepted on a rising edge when i_rd_en=1 and
// o_empty=0; a read request while o_empty=1 is ignored with no side effects.
module rd_ptr_empty_tx #(
    parameter int PTR_W     = 12,
    parameter int AE_THRESH = 4
) (
    input  logic             i_rd_clk,
    input  logic             i_rd_rstn,
    input  logic             i_rd_en,
    input  logic [PTR_W:0]   i_wr_ptr_gray,
    output logic [PTR_W-1:0] o_rd_addr,
    output logic [PTR_W:0]   o_rd_ptr_gray,
    output logic             o_empty,
    output logic             o_almost_empty,
    output logic [PTR_W:0]   o_rd_count
);

`ifdef SYNC_3FF_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    localparam logic [PTR_W:0] AE_LIMIT = (PTR_W+1)'(AE_THRESH);

    logic [PTR_W:0] wr_sync_q [SYNC_STAGES];
    logic [PTR_W:0] wr_sync;
    logic [PTR_W:0] wr_bin_sync;

    logic [PTR_W:0] rd_bin_q,  rd_bin_d;
    logic [PTR_W:0] rd_gray_q, rd_gray_d;
    logic [PTR_W:0] count_q,   count_d;
    logic           empty_q,   empty_d;
    logic           ae_q,      ae_d;
    logic           rd_go;

    // Multi-flop synchroniser for the Gray write pointer crossing into i_rd_clk.
    always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
        if (!i_rd_rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wr_sync_q[i] <= '0;
            end
        end else begin
            wr_sync_q[0] <= i_wr_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wr_sync_q[i] <= wr_sync_q[i-1];
            end
        end
    end

    assign wr_sync = wr_sync_q[SYNC_STAGES-1];

    // Next read pointer, Gray decode of the synchronised write pointer, and
    // flags computed from the next pointer so empty is exact right after the
    // last read.
    always_comb begin
        rd_go     = i_rd_en & ~empty_q;
        rd_bin_d  = rd_bin_q + {{PTR_W{1'b0}}, rd_go};
        rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);
        wr_bin_sync = '0;
        for (int i = 0; i <= PTR_W; i++) begin
            wr_bin_sync[i] = ^(wr_sync >> i);
        end
        count_d = wr_bin_sync - rd_bin_d;
        empty_d = (rd_gray_d == wr_sync);
        ae_d    = (count_d <= AE_LIMIT);
    end

    // Pointer and flag registers; the Gray pointer leaves the block from a flop.
    always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
        if (!i_rd_rstn) begin
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            ae_q      <= 1'b1;
        end else begin
            rd_bin_q  <= rd_bin_d;
            rd_gray_q <= rd_gray_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            ae_q      <= ae_d;
        end
    end

    assign o_rd_addr      = rd_bin_q[PTR_W-1:0];
    assign o_rd_ptr_gray  = rd_gray_q;
    assign o_empty        = empty_q;
    assign o_almost_empty = ae_q;
    assign o_rd_count     = count_q;

endmodule

// File: tb/tb_rd_ptr_empty_tx.sv
// Self-checking bench for rd_ptr_empty_tx (PTR_W=3, AE_THRESH=4).
module tb_rd_ptr_empty_tx;

    localparam int PTR_W = 3;
    localparam int AE    = 4;
`ifdef SYNC_3FF_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int W = 13;  // {addr[2:0], gray[3:0], empty, ae, count[3:0]}

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rstn;
    logic       rd_en;
    logic [3:0] wr_gray;
    logic [2:0] o_rd_addr;
    logic [3:0] o_rd_ptr_gray;
    logic       o_empty;
    logic       o_almost_empty;
    logic [3:0] o_rd_count;

    always #5 clk = ~clk;

    rd_ptr_empty_tx #(.PTR_W(PTR_W), .AE_THRESH(AE)) dut (
        .i_rd_clk       (clk),
        .i_rd_rstn      (rstn),
        .i_rd_en        (rd_en),
        .i_wr_ptr_gray  (wr_gray),
        .o_rd_addr      (o_rd_addr),
        .o_rd_ptr_gray  (o_rd_ptr_gray),
        .o_empty        (o_empty),
        .o_almost_empty (o_almost_empty),
        .o_rd_count     (o_rd_count)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       rd_en;
        logic [3:0] wr_gray;
        int         n_edges;
        logic [2:0] addr;
        logic [3:0] gray;
        logic       empty;
        logic       ae;
        logic [3:0] count;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] pack(input logic [2:0] a, input logic [3:0] gr,
                                          input logic e, input logic ae,
                                          input logic [3:0] c);
        return {a, gr, e, ae, c};
    endfunction

    localparam logic [W-1:0] RST_VAL = {3'd0, 4'h0, 1'b1, 1'b1, 4'd0};

    task automatic check_out(input string name);
        logic [W-1:0] act;
        logic [W-1:0] exp;
        act = pack(o_rd_addr, o_rd_ptr_gray, o_empty, o_almost_empty, o_rd_count);
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard had no expected entry", name);
            return;
        end
        exp = exp_q.pop_front();
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got addr=%0d gray=%h empty=%b ae=%b count=%0d, want addr=%0d gray=%h empty=%b ae=%b count=%0d",
                     name, $time, act[12:10], act[9:6], act[5], act[4], act[3:0],
                     exp[12:10], exp[9:6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive inputs, push expectation, take one rising edge, sample 1 time unit later.
    task automatic cycle(input logic rd, input logic [3:0] wg,
                         input logic [W-1:0] exp, input string name);
        rd_en   = rd;
        wr_gray = wg;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    // Assert reset between edges, check the asynchronous effect, release on negedge.
    task automatic do_reset(input string name);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        exp_q.push_back(RST_VAL);
        check_out(name);
        rd_en   = 1'b0;
        wr_gray = 4'h0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // ---------------- test ----------------
    logic [3:0] m_rd, m_wr, m_cnt, prev_gray;
    logic [3:0] m_stage[LAT-1];
    logic       m_empty, m_go, m_rd_en, m_e, m_ae;
    int         n_written;

    initial begin
        vecs[0] = '{1'b1, 4'h7, 1, 3'd1, 4'h1, 1'b0, 1'b1, 4'd4};
        vecs[1] = '{1'b1, 4'h7, 1, 3'd2, 4'h3, 1'b0, 1'b1, 4'd3};
        vecs[2] = '{1'b1, 4'h7, 1, 3'd3, 4'h2, 1'b0, 1'b1, 4'd2};
        vecs[3] = '{1'b1, 4'h7, 1, 3'd4, 4'h6, 1'b0, 1'b1, 4'd1};
        vecs[4] = '{1'b1, 4'h7, 1, 3'd5, 4'h7, 1'b1, 1'b1, 4'd0};
        vecs[5] = '{1'b1, 4'h7, 3, 3'd5, 4'h7, 1'b1, 1'b1, 4'd0};

        rstn    = 1'b0;
        rd_en   = 1'b0;
        wr_gray = 4'h0;
        do_reset("reset");

        // Read requests while empty are ignored.
        for (int i = 0; i < 10; i++) cycle(1'b1, 4'h0, RST_VAL, "idle_rd");

        // Write pointer steps to Gray(5): visible exactly LAT edges later.
        for (int e = 1; e <= LAT; e++)
            cycle(1'b0, 4'h7, (e < LAT) ? RST_VAL : pack(3'd0, 4'h0, 1'b0, 1'b0, 4'd5), "wr_step_lat");

        // Drain five entries, then hold once empty.
        for (int v = 0; v < 6; v++)
            for (int k = 0; k < vecs[v].n_edges; k++)
                cycle(vecs[v].rd_en, vecs[v].wr_gray,
                      pack(vecs[v].addr, vecs[v].gray, vecs[v].empty, vecs[v].ae, vecs[v].count),
                      "drain_vec");

        // Wrap: 20 writes while draining randomly, checked against a binary-count model.
        do_reset("reset_wrap");
        m_rd = '0; m_wr = '0; m_empty = 1'b1; n_written = 0; prev_gray = '0;
        for (int i = 0; i < LAT-1; i++) m_stage[i] = '0;
        for (int c = 0; c < 150; c++) begin
            if (n_written < 20 && 4'(m_wr - m_rd) < 4'd8 && $urandom_range(0, 3) != 0) begin
                m_wr = m_wr + 4'd1;
                n_written++;
            end
            m_rd_en = ($urandom_range(0, 3) != 0);
            m_go  = m_rd_en && !m_empty;
            m_rd  = m_rd + {3'd0, m_go};
            m_cnt = m_stage[LAT-2] - m_rd;
            m_e   = (m_cnt == 4'd0);
            m_ae  = (m_cnt <= 4'(AE));
            for (int s = LAT-2; s > 0; s--) m_stage[s] = m_stage[s-1];
            m_stage[0] = m_wr;
            m_empty = m_e;
            cycle(m_rd_en, to_gray(m_wr), pack(m_rd[2:0], to_gray(m_rd), m_e, m_ae, m_cnt), "wrap_model");
            n_checks++;
            if ($countones(prev_gray ^ o_rd_ptr_gray) <= 1) n_pass++;
            else $display("FAIL gray_one_bit: prev=%h now=%h", prev_gray, o_rd_ptr_gray);
            prev_gray = o_rd_ptr_gray;
        end

        // Full FIFO: write pointer Gray(8), read pointer 0, must not look empty.
        do_reset("reset_full");
        for (int e = 1; e <= LAT; e++)
            cycle(1'b0, 4'hC, (e < LAT) ? RST_VAL : pack(3'd0, 4'h0, 1'b0, 1'b0, 4'd8), "full_lat");
        for (int k = 1; k <= 5; k++) begin
            logic [3:0] kb;
            kb = 4'(k);
            cycle(1'b1, 4'hC, pack(kb[2:0], to_gray(kb), 1'b0, (k >= 4), 4'(8 - k)), "full_drain");
        end

        // Asynchronous reset mid-drain (count=3), then stay empty with wr pointer 0.
        do_reset("mid_reset");
        for (int i = 0; i < 6; i++) cycle(1'b1, 4'h0, RST_VAL, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
